// File: rtl/seg_scan_if.sv
// Requester and display-pin bundle for the 7-segment scan arbiter.
// The slave side is the arbiter itself; the master side drives requests and watches the pins.
interface seg_scan_if;
  logic        req0;
  logic [27:0] seg0;
  logic        req1;
  logic [27:0] seg1;
  logic [1:0]  grant;
  logic        sclk;
  logic        sdata;
  logic        latch;
  logic        scan_done;

  modport master (
    output req0, seg0, req1, seg1,
    input  grant, sclk, sdata, latch, scan_done
  );

  modport slave (
    input  req0, seg0, req1, seg1,
    output grant, sclk, sdata, latch, scan_done
  );
endinterface

// File: rtl/seg_scan_arbiter.sv
// Arbitrates two segment-image requesters and scans the granted image into the
// serial display chain, one 16-bit frame per digit, latching after every frame.
//
// state   | meaning
// S_LOAD  | build frame for current digit; arbitrate and snapshot when digit==0
// S_SHIFT | shift 16 bits MSB first, 2*CLK_DIV cycles per bit
// S_LATCH | hold latch high for CLK_DIV cycles, then advance digit
module seg_scan_arbiter #(
  parameter int CLK_DIV    = 4,
  parameter int HOLD_SCANS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_scan_if.slave  bus
);

  localparam int TW = $clog2(2 * CLK_DIV + 1);
  localparam int HW = $clog2(HOLD_SCANS + 1);
  localparam logic [TW-1:0] BIT_LAST   = TW'(2 * CLK_DIV - 1);
  localparam logic [TW-1:0] HALF       = TW'(CLK_DIV);
  localparam logic [TW-1:0] LATCH_LAST = TW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_SCANS);

  typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_LATCH} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tmr;
  logic [3:0]      bit_cnt;
  logic [1:0]      digit;
  logic [15:0]     shreg;
  logic [1:0]      grant_q;
  logic [27:0]     snap;
  logic [HW-1:0]   hold_cnt;
  logic            done_q;

  logic [1:0]      grant_nxt;
  logic [27:0]     img_nxt;
  logic [27:0]     img;
  logic [6:0]      seg_sel;
  logic [15:0]     frame;
  logic            at_boundary;
  logic            sclk_c;
  logic            sdata_c;
  logic            latch_c;

  assign at_boundary = (state == S_LOAD) && (digit == 2'd0);

  // An owner that drops its request loses the display at once; otherwise a
  // contender only gets in once the hold has expired.
  always_comb begin
    grant_nxt = grant_q;
    if ((grant_q == 2'b00) || (grant_q == 2'b01 && !bus.req0) ||
        (grant_q == 2'b10 && !bus.req1)) begin
      if (bus.req0)      grant_nxt = 2'b01;
      else if (bus.req1) grant_nxt = 2'b10;
      else               grant_nxt = 2'b00;
    end else if (hold_cnt >= HOLD_MAX) begin
      if (grant_q == 2'b01 && bus.req1)      grant_nxt = 2'b10;
      else if (grant_q == 2'b10 && bus.req0) grant_nxt = 2'b01;
    end
  end

  always_comb begin
    img_nxt = 28'd0;
    if (grant_nxt == 2'b01)      img_nxt = bus.seg0;
    else if (grant_nxt == 2'b10) img_nxt = bus.seg1;
  end

  // Digit 0 is built from the image being snapshotted this same cycle.
  assign img = at_boundary ? img_nxt : snap;

  always_comb begin
    seg_sel = 7'd0;
    unique case (digit)
      2'd0: seg_sel = img[6:0];
      2'd1: seg_sel = img[13:7];
      2'd2: seg_sel = img[20:14];
      2'd3: seg_sel = img[27:21];
      default: seg_sel = 7'd0;
    endcase
  end

  assign frame = {1'b0, seg_sel, 4'b0000, 4'b0001 << digit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sclk_c    = 1'b0;
    sdata_c   = 1'b0;
    latch_c   = 1'b0;
    unique case (state)
      S_LOAD: state_nxt = S_SHIFT;
      S_SHIFT: begin
        sclk_c  = (tmr < HALF);
        sdata_c = shreg[15];
        if (tmr == '0 && bit_cnt == 4'd0) state_nxt = S_LATCH;
      end
      S_LATCH: begin
        latch_c = 1'b1;
        if (tmr == '0) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr      <= '0;
      bit_cnt  <= 4'd0;
      digit    <= 2'd0;
      shreg    <= 16'd0;
      grant_q  <= 2'b00;
      snap     <= 28'd0;
      hold_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_LOAD: begin
          shreg   <= frame;
          tmr     <= BIT_LAST;
          bit_cnt <= 4'd15;
          if (digit == 2'd0) begin
            grant_q <= grant_nxt;
            snap    <= img_nxt;
            if (grant_nxt != grant_q) hold_cnt <= '0;
          end
        end
        S_SHIFT: begin
          if (tmr == '0) begin
            shreg <= {shreg[14:0], 1'b0};
            if (bit_cnt == 4'd0) begin
              tmr <= LATCH_LAST;
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
              tmr     <= BIT_LAST;
            end
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_LATCH: begin
          if (tmr == '0) begin
            digit <= digit + 2'd1;
            if (digit == 2'd3) begin
              done_q <= 1'b1;
              if (hold_cnt < HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
            end
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        default: tmr <= '0;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.sclk      = sclk_c;
  assign bus.sdata     = sdata_c;
  assign bus.latch     = latch_c;
  assign bus.scan_done = done_q;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Directed bench for seg_scan_arbiter at CLK_DIV=2, HOLD_SCANS=2 (67-cycle frames,
// 268-cycle scans); a pin monitor rebuilds frames and timing for comparison.
module tb_seg_scan_arbiter;

  logic clk;
  logic rst_n;
  seg_scan_if bus ();

  seg_scan_arbiter #(.CLK_DIV(2), .HOLD_SCANS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  int frames[$];
  int fgrant[$];
  int latch_cyc[$];
  int lfall_cyc[$];
  int done_cyc[$];
  int cyc = 0;
  int latch_in_rst = 0;
  logic [15:0] shreg = 16'd0;
  logic sclk_prev = 1'b0;
  logic latch_prev = 1'b0;

  // Pin monitor, sampled on the falling edge; cyc counts frame-relative cycles from 1.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc = 0;
        shreg = 16'd0;
        sclk_prev = 1'b0;
        latch_prev = 1'b0;
        frames.delete();
        fgrant.delete();
        latch_cyc.delete();
        lfall_cyc.delete();
        done_cyc.delete();
        if (bus.latch) latch_in_rst++;
      end else begin
        cyc++;
        if (bus.sclk && !sclk_prev) shreg = {shreg[14:0], bus.sdata};
        if (bus.latch && !latch_prev) begin
          frames.push_back(int'(shreg));
          fgrant.push_back(int'(bus.grant));
          latch_cyc.push_back(cyc);
        end
        if (!bus.latch && latch_prev) lfall_cyc.push_back(cyc);
        if (bus.scan_done) done_cyc.push_back(cyc);
        sclk_prev = bus.sclk;
        latch_prev = bus.latch;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_frames(input string tag, input int n);
    int k = 0;
    while (frames.size() < n && k < 4000) begin
      @(posedge clk);
      k++;
    end
    check(tag, int'(frames.size() >= n), 1);
  endtask

  task automatic set_req(input logic r0, input logic [27:0] s0,
                         input logic r1, input logic [27:0] s1);
    bus.req0 = r0;
    bus.seg0 = s0;
    bus.req1 = r1;
    bus.seg1 = s1;
  endtask

  localparam int EXP_IDLE[4] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
  localparam int EXP_OLD[4]  = '{16'h0101, 16'h0202, 16'h0304, 16'h0408};
  localparam int EXP_NEW[4]  = '{16'h1101, 16'h2202, 16'h3304, 16'h4408};
  localparam int EXP_HOLD_G[6] = '{1, 1, 2, 2, 1, 1};

  initial begin
    rst_n = 1'b0;
    set_req(1'b0, 28'd0, 1'b0, 28'd0);
    #3;
    check("rst_grant", int'(bus.grant), 0);
    check("rst_sclk", int'(bus.sclk), 0);
    check("rst_sdata", int'(bus.sdata), 0);
    check("rst_latch", int'(bus.latch), 0);
    check("rst_done", int'(bus.scan_done), 0);

    // Idle: blank frames, digit select still cycles.
    do_reset();
    wait_frames("idle_frames", 9);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("idle_frame%0d", d), qi(frames, d), EXP_IDLE[d]);
      check($sformatf("idle_grant%0d", d), qi(fgrant, d), 0);
    end
    check("latch_rise0", qi(latch_cyc, 0), 66);
    check("latch_width", qi(lfall_cyc, 0) - qi(latch_cyc, 0), 2);
    check("latch_rise1", qi(latch_cyc, 1), 133);
    check("done_first", qi(done_cyc, 0), 269);
    check("done_period", qi(done_cyc, 1) - qi(done_cyc, 0), 268);

    // Single requester with digit 0 fully lit.
    set_req(1'b1, 28'h000007F, 1'b0, 28'd0);
    do_reset();
    wait_frames("req0_frames", 4);
    check("req0_frame0", qi(frames, 0), 16'h7F01);
    check("req0_frame1", qi(frames, 1), 16'h0002);
    check("req0_frame2", qi(frames, 2), 16'h0004);
    check("req0_frame3", qi(frames, 3), 16'h0008);
    check("req0_grant", qi(fgrant, 0), 1);

    // Hold and round-robin: 01 for two scans, 10 for two, then 01 again.
    set_req(1'b1, 28'h0000011, 1'b0, 28'h0000022);
    do_reset();
    wait_frames("hold_first", 1);
    bus.req1 = 1'b1;
    wait_frames("hold_frames", 24);
    for (int s = 0; s < 6; s++) begin
      check($sformatf("hold_grant_scan%0d", s), qi(fgrant, 4 * s), EXP_HOLD_G[s]);
      check($sformatf("hold_frame_scan%0d", s), qi(frames, 4 * s),
            (EXP_HOLD_G[s] == 1) ? 16'h1101 : 16'h2201);
    end

    // Image change in the middle of digit 1 only shows from the next scan.
    set_req(1'b1, {7'h04, 7'h03, 7'h02, 7'h01}, 1'b0, 28'd0);
    do_reset();
    wait_frames("snap_first", 1);
    repeat (20) @(posedge clk);
    bus.seg0 = {7'h44, 7'h33, 7'h22, 7'h11};
    wait_frames("snap_frames", 8);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("snap_old%0d", d), qi(frames, d), EXP_OLD[d]);
      check($sformatf("snap_new%0d", d), qi(frames, 4 + d), EXP_NEW[d]);
    end

    // Owner drops with the hold still running: switch at the next boundary.
    set_req(1'b1, 28'h0000011, 1'b1, 28'h0000022);
    do_reset();
    wait_frames("drop_first", 1);
    bus.req0 = 1'b0;
    wait_frames("drop_frames", 8);
    check("drop_grant0", qi(fgrant, 0), 1);
    check("drop_frame0", qi(frames, 0), 16'h1101);
    check("drop_grant1", qi(fgrant, 4), 2);
    check("drop_frame1", qi(frames, 4), 16'h2201);

    // Reset asserted mid-bit of the first frame, with sclk high.
    set_req(1'b1, 28'h000007F, 1'b0, 28'd0);
    do_reset();
    repeat (35) @(posedge clk);
    #7;
    check("mid_sclk_before", int'(bus.sclk), 1);
    rst_n = 1'b0;
    #1;
    check("mid_grant", int'(bus.grant), 0);
    check("mid_sclk", int'(bus.sclk), 0);
    check("mid_sdata", int'(bus.sdata), 0);
    check("mid_latch", int'(bus.latch), 0);
    check("mid_done", int'(bus.scan_done), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_frames("mid_frames", 2);
    check("mid_no_latch", latch_in_rst, 0);
    check("mid_restart_frame", qi(frames, 0), 16'h7F01);
    check("mid_restart_frame1", qi(frames, 1), 16'h0002);
    check("mid_restart_latch", qi(latch_cyc, 0), 66);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
